// File: rtl/board_pkg.sv
// Shared types for the board grid: cell marks, game FSM states, winner codes.
package board_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b01,
        O     = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        PLAY,
        CHECK,
        OVER
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;

endpackage

// File: rtl/board_cell.sv
// One board cell: 2-bit mark register with write-enable and clear.
module board_cell
    import board_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  we,
    input  logic  clear,
    input  cell_t d,
    output cell_t q
);

    always_ff @(posedge clock) begin
        if (reset || clear)
            q <= EMPTY;
        else if (we)
            q <= d;
    end

endmodule

// File: rtl/board_grid.sv
// N x N tic-tac-toe style board with move checking and win/draw detection.
// Define BOARD_GRID_UNDO_EN to add a one-level undo port.
module board_grid
    import board_pkg::*;
#(
    parameter int N = 3
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       select,
    input  logic [$clog2(N)-1:0]       row,
    input  logic [$clog2(N)-1:0]       col,
`ifdef BOARD_GRID_UNDO_EN
    input  logic                       undo,
`endif
    output logic [2*N*N-1:0]           board,
    output logic                       turn,
    output logic                       move_ok,
    output logic                       move_err,
    output logic [1:0]                 winner,
    output logic                       game_over,
    output logic                       draw,
    output logic [$clog2(N*N+1)-1:0]   move_count
);

    localparam int CW = $clog2(N*N+1);
    localparam logic [CW-1:0] FULL = CW'(N*N);

    state_t        state, state_n;
    cell_t         mark;
    logic [N*N-1:0] we, clr;
    logic          legal, win, line, commit, req;
    logic          turn_n, ok_n, err_n, over_n, draw_n;
    logic [1:0]    winner_n;
    logic [CW-1:0] count_n;
    int            sel_idx;

`ifdef BOARD_GRID_UNDO_EN
    localparam int IW = $clog2(N*N);
    logic          urec, urec_n, undo_do;
    logic [IW-1:0] uidx, uidx_n;
    assign req = select | undo;
`else
    assign req = select;
`endif

    assign mark = turn ? O : X;

    always_comb sel_idx = int'(row) * N + int'(col);

    for (genvar i = 0; i < N*N; i++) begin : g_cell
        board_cell u_cell (
            .clock (clock),
            .reset (reset),
            .we    (we[i]),
            .clear (clr[i]),
            .d     (mark),
            .q     (board[2*i +: 2])
        );
    end

    always_comb begin
        legal = 1'b0;
        for (int i = 0; i < N*N; i++)
            if (i == sel_idx && board[2*i +: 2] == EMPTY)
                legal = 1'b1;
        if (int'(row) >= N || int'(col) >= N)
            legal = 1'b0;
    end

    // Only the player who just moved can have completed a line.
    always_comb begin
        win = 1'b0;
        for (int r = 0; r < N; r++) begin
            line = 1'b1;
            for (int c = 0; c < N; c++)
                line = line & (board[2*(r*N+c) +: 2] == mark);
            win = win | line;
        end
        for (int c = 0; c < N; c++) begin
            line = 1'b1;
            for (int r = 0; r < N; r++)
                line = line & (board[2*(r*N+c) +: 2] == mark);
            win = win | line;
        end
        line = 1'b1;
        for (int i = 0; i < N; i++)
            line = line & (board[2*(i*N+i) +: 2] == mark);
        win = win | line;
        line = 1'b1;
        for (int i = 0; i < N; i++)
            line = line & (board[2*(i*N+N-1-i) +: 2] == mark);
        win = win | line;
    end

    always_comb begin
        state_n  = state;
        turn_n   = turn;
        winner_n = winner;
        over_n   = game_over;
        draw_n   = draw;
        count_n  = move_count;
        ok_n     = 1'b0;
        err_n    = 1'b0;
        commit   = 1'b0;
`ifdef BOARD_GRID_UNDO_EN
        urec_n   = urec;
        uidx_n   = uidx;
        undo_do  = 1'b0;
`endif
        unique case (state)
            PLAY: begin
                if (select) begin
                    if (legal) begin
                        commit  = 1'b1;
                        count_n = move_count + 1'b1;
                        ok_n    = 1'b1;
                        state_n = CHECK;
`ifdef BOARD_GRID_UNDO_EN
                        urec_n  = 1'b1;
                        uidx_n  = IW'(sel_idx);
`endif
                    end else begin
                        err_n = 1'b1;
                    end
                end
`ifdef BOARD_GRID_UNDO_EN
                else if (undo) begin
                    if (urec) begin
                        undo_do = 1'b1;
                        count_n = move_count - 1'b1;
                        turn_n  = ~turn;
                        urec_n  = 1'b0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
`endif
            end
            CHECK: begin
                err_n = req;
                if (win) begin
                    winner_n = turn ? WIN_O : WIN_X;
                    over_n   = 1'b1;
                    state_n  = OVER;
                end else if (move_count == FULL) begin
                    draw_n  = 1'b1;
                    over_n  = 1'b1;
                    state_n = OVER;
                end else begin
                    turn_n  = ~turn;
                    state_n = PLAY;
                end
            end
            OVER: err_n = req;
            default: state_n = PLAY;
        endcase
    end

    always_comb begin
        we  = '0;
        clr = '0;
        for (int i = 0; i < N*N; i++) begin
            we[i] = commit && (i == sel_idx);
`ifdef BOARD_GRID_UNDO_EN
            clr[i] = undo_do && (IW'(i) == uidx);
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= PLAY;
            turn       <= 1'b0;
            winner     <= WIN_NONE;
            game_over  <= 1'b0;
            draw       <= 1'b0;
            move_ok    <= 1'b0;
            move_err   <= 1'b0;
            move_count <= '0;
        end else begin
            state      <= state_n;
            turn       <= turn_n;
            winner     <= winner_n;
            game_over  <= over_n;
            draw       <= draw_n;
            move_ok    <= ok_n;
            move_err   <= err_n;
            move_count <= count_n;
        end
    end

`ifdef BOARD_GRID_UNDO_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            urec <= 1'b0;
            uidx <= '0;
        end else begin
            urec <= urec_n;
            uidx <= uidx_n;
        end
    end
`endif

endmodule

// File: tb/tb_board_grid.sv
// Scoreboard bench for board_grid (N=3 and N=4 instances).
`timescale 1ns/1ps
module tb_board_grid;

    logic clock = 1'b0;
    logic reset;
    logic sel3, sel4;
    logic [1:0] row3, col3, row4, col4;
    logic [17:0] board3;
    logic [31:0] board4;
    logic turn3, ok3, err3, over3, draw3;
    logic turn4, ok4, err4, over4, draw4;
    logic [1:0] win3, win4;
    logic [3:0] cnt3;
    logic [4:0] cnt4;
`ifdef BOARD_GRID_UNDO_EN
    logic undo3, undo4;
`endif

    always #5 clock = ~clock;

    board_grid #(.N(3)) u3 (
        .clock(clock), .reset(reset), .select(sel3),
        .row(row3), .col(col3),
`ifdef BOARD_GRID_UNDO_EN
        .undo(undo3),
`endif
        .board(board3), .turn(turn3), .move_ok(ok3),
        .move_err(err3), .winner(win3), .game_over(over3),
        .draw(draw3), .move_count(cnt3)
    );

    board_grid #(.N(4)) u4 (
        .clock(clock), .reset(reset), .select(sel4),
        .row(row4), .col(col4),
`ifdef BOARD_GRID_UNDO_EN
        .undo(undo4),
`endif
        .board(board4), .turn(turn4), .move_ok(ok4),
        .move_err(err4), .winner(win4), .game_over(over4),
        .draw(draw4), .move_count(cnt4)
    );

    typedef struct {
        string name;
        bit    ok;
        int    cnt;
    } exp_t;

    exp_t q3[$];
    exp_t q4[$];
    exp_t e3, e4;
    int checks = 0;
    int errors = 0;

    // Monitors: every response pulse must match the oldest pending request.
    always @(negedge clock) begin
        if (ok3 || err3) begin
            checks++;
            if (q3.size() == 0) begin
                errors++;
                $display("FAIL u3 unexpected pulse: ok=%b err=%b", ok3, err3);
            end else begin
                e3 = q3.pop_front();
                if (ok3 !== e3.ok || err3 !== !e3.ok || int'(cnt3) != e3.cnt) begin
                    errors++;
                    $display("FAIL u3 %s: ok=%b err=%b cnt=%0d, want ok=%b err=%b cnt=%0d",
                             e3.name, ok3, err3, cnt3, e3.ok, !e3.ok, e3.cnt);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (ok4 || err4) begin
            checks++;
            if (q4.size() == 0) begin
                errors++;
                $display("FAIL u4 unexpected pulse: ok=%b err=%b", ok4, err4);
            end else begin
                e4 = q4.pop_front();
                if (ok4 !== e4.ok || err4 !== !e4.ok || int'(cnt4) != e4.cnt) begin
                    errors++;
                    $display("FAIL u4 %s: ok=%b err=%b cnt=%0d, want ok=%b err=%b cnt=%0d",
                             e4.name, ok4, err4, cnt4, e4.ok, !e4.ok, e4.cnt);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, got, exp);
        end
    endtask

    task automatic mv3(input int r, input int c, input bit ok, input int cnt, input string nm);
        q3.push_back('{nm, ok, cnt});
        row3 = r[1:0];
        col3 = c[1:0];
        sel3 = 1'b1;
        @(posedge clock); #1;
        sel3 = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic mv4(input int r, input int c, input bit ok, input int cnt, input string nm);
        q4.push_back('{nm, ok, cnt});
        row4 = r[1:0];
        col4 = c[1:0];
        sel4 = 1'b1;
        @(posedge clock); #1;
        sel4 = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        sel3 = 1'b0; row3 = '0; col3 = '0;
        sel4 = 1'b0; row4 = '0; col4 = '0;
`ifdef BOARD_GRID_UNDO_EN
        undo3 = 1'b0;
        undo4 = 1'b0;
`endif
        do_reset();

        chk("rst board", 64'(board3), 0);
        chk("rst turn", 64'(turn3), 0);
        chk("rst winner", 64'(win3), 0);
        chk("rst over", 64'(over3), 0);
        chk("rst draw", 64'(draw3), 0);
        chk("rst count", 64'(cnt3), 0);
        chk("rst ok", 64'(ok3), 0);
        chk("rst err", 64'(err3), 0);
        chk("rst board4", 64'(board4), 0);

        // X wins top row
        mv3(0, 0, 1, 1, "A1");
        mv3(1, 0, 1, 2, "A2");
        mv3(0, 1, 1, 3, "A3");
        mv3(1, 1, 1, 4, "A4");
        chk("A turn mid", 64'(turn3), 0);
        chk("A over mid", 64'(over3), 0);
        mv3(0, 2, 1, 5, "A5");
        chk("A winner", 64'(win3), 1);
        chk("A over", 64'(over3), 1);
        chk("A draw", 64'(draw3), 0);
        chk("A count", 64'(cnt3), 5);
        chk("A turn", 64'(turn3), 0);
        chk("A board", 64'(board3), 64'h295);
        mv3(2, 2, 0, 5, "A sel in OVER");
        chk("A board after", 64'(board3), 64'h295);

        // occupied and out-of-range moves
        do_reset();
        mv3(1, 1, 1, 1, "B1");
        mv3(1, 1, 0, 1, "B dup");
        mv3(3, 0, 0, 1, "B row oob");
        mv3(0, 3, 0, 1, "B col oob");
        chk("B count", 64'(cnt3), 1);
        chk("B turn", 64'(turn3), 1);
        chk("B board", 64'(board3), 64'h100);

        // draw
        do_reset();
        mv3(0, 0, 1, 1, "C1");
        mv3(1, 1, 1, 2, "C2");
        mv3(2, 2, 1, 3, "C3");
        mv3(0, 1, 1, 4, "C4");
        mv3(2, 1, 1, 5, "C5");
        mv3(2, 0, 1, 6, "C6");
        mv3(0, 2, 1, 7, "C7");
        mv3(1, 2, 1, 8, "C8");
        chk("C over mid", 64'(over3), 0);
        mv3(1, 0, 1, 9, "C9");
        chk("C draw", 64'(draw3), 1);
        chk("C over", 64'(over3), 1);
        chk("C winner", 64'(win3), 0);
        chk("C count", 64'(cnt3), 9);
        chk("C turn", 64'(turn3), 0);

        // reset during the CHECK cycle of a winning move
        do_reset();
        mv3(0, 0, 1, 1, "D1");
        mv3(1, 0, 1, 2, "D2");
        mv3(0, 1, 1, 3, "D3");
        mv3(1, 1, 1, 4, "D4");
        q3.push_back('{"D5", 1'b1, 5});
        row3 = 2'd0; col3 = 2'd2; sel3 = 1'b1;
        @(posedge clock); #1;
        sel3 = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("D board", 64'(board3), 0);
        chk("D winner", 64'(win3), 0);
        chk("D over", 64'(over3), 0);
        chk("D draw", 64'(draw3), 0);
        chk("D count", 64'(cnt3), 0);
        chk("D turn", 64'(turn3), 0);
        chk("D ok", 64'(ok3), 0);
        chk("D err", 64'(err3), 0);
        mv3(2, 2, 1, 1, "D after");
        chk("D turn after", 64'(turn3), 1);

        // N=4: O wins on the anti-diagonal
        mv4(0, 0, 1, 1, "E1");
        mv4(0, 3, 1, 2, "E2");
        mv4(0, 1, 1, 3, "E3");
        mv4(1, 2, 1, 4, "E4");
        mv4(0, 2, 1, 5, "E5");
        mv4(2, 1, 1, 6, "E6");
        mv4(1, 0, 1, 7, "E7");
        chk("E over mid", 64'(over4), 0);
        mv4(3, 0, 1, 8, "E8");
        chk("E winner", 64'(win4), 2);
        chk("E over", 64'(over4), 1);
        chk("E turn", 64'(turn4), 1);
        chk("E count", 64'(cnt4), 8);
        mv4(3, 3, 0, 8, "E sel in OVER");

`ifdef BOARD_GRID_UNDO_EN
        do_reset();
        mv3(2, 2, 1, 1, "U1");
        undo3 = 1'b1;
        @(posedge clock); #1;
        undo3 = 1'b0;
        @(posedge clock); #1;
        chk("U board", 64'(board3), 0);
        chk("U turn", 64'(turn3), 0);
        chk("U count", 64'(cnt3), 0);
        q3.push_back('{"U second", 1'b0, 0});
        undo3 = 1'b1;
        @(posedge clock); #1;
        undo3 = 1'b0;
        @(posedge clock); #1;
        chk("U count after", 64'(cnt3), 0);
`endif

        @(posedge clock); #1;
        chk("q3 drained", 64'(q3.size()), 0);
        chk("q4 drained", 64'(q4.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
